calc_display_scan: RTL and testbench

- Downstream stage of calc_top: consumes its eight 7-segment digit patterns (`displays`) and its `status`.
- Time-multiplexes the eight digits onto a single shared segment bus with one-hot digit-enable lines, as required by the physical 8-digit display.
- Takes a frame-coherent snapshot of `displays` so a digit never changes mid-frame.
- Inserts dead-time blanking between digits to suppress ghosting, and blinks the whole display while calc_top reports error.

---
 rtl/calc_display_scan.sv | 96 +++++++++
 tb/tb_calc_display_scan.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_display_scan.sv
// Eight-digit 7-segment scanner: frame-coherent snapshot of the digit patterns,
// one-hot-low digit enables with dead-time blanking, and whole-display blink on error.
module calc_display_scan #(
    parameter int         DIV          = 4,
    parameter int         DEAD         = 1,
    parameter int         BLINK_FRAMES = 2,
    parameter logic [1:0] ERR_STATUS   = 2'd2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] displays [7:0],
    input  logic [1:0] status,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       frame_tick
);

    localparam int CW = $clog2(DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] DEAD_CNT   = CW'(DEAD);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [7:0]    AN_OFF     = 8'hFF;
    localparam logic [6:0]    SEG_OFF    = 7'h7F;

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [6:0]    shadow [7:0];
    logic [FW-1:0] frame_cnt;
    logic          blink_off;

    logic frame_end;
    logic in_dead;
    logic in_error;

    assign frame_end = (cnt == CNT_LAST) && (idx == 3'd7);
    assign in_dead   = (DEAD > 0) && (cnt < DEAD_CNT);
    assign in_error  = (status == ERR_STATUS);

    // NOTE: every register below is written with <= so all of them sample the
    // same pre-edge state; blocking assignments here would leak new values forward.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= '0;
            frame_cnt  <= '0;
            blink_off  <= 1'b0;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            frame_tick <= 1'b0;
            // NOTE: the shadow is only eight registers and must read as blank after
            // reset, so it is reset explicitly rather than treated as a RAM.
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= SEG_OFF;
            end
        end else begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= idx + 3'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end

            // Snapshot only at the frame boundary so a digit never changes mid-frame.
            frame_tick <= frame_end;
            if (frame_end) begin
                for (int i = 0; i < 8; i++) begin
                    shadow[i] <= displays[i];
                end
            end

            if (in_dead || blink_off) begin
                an  <= AN_OFF;
                seg <= SEG_OFF;
            end else begin
                an  <= ~(8'b1 << idx);
                seg <= shadow[idx];
            end

            // Leaving error clears the blink phase at once, so re-entry starts "on".
            if (!in_error) begin
                frame_cnt <= '0;
                blink_off <= 1'b0;
            end else if (frame_end) begin
                if (frame_cnt == FRAME_LAST) begin
                    frame_cnt <= '0;
                    blink_off <= ~blink_off;
                end else begin
                    frame_cnt <= frame_cnt + FW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_calc_display_scan.sv
// Self-checking bench for calc_display_scan: directed scenarios plus random stimulus
// against a frame/slot arithmetic reference model.
module tb_calc_display_scan;

    localparam int         DIV   = 4;
    localparam int         DEAD  = 1;
    localparam int         BF    = 2;
    localparam logic [1:0] ERR   = 2'd2;
    localparam int         FRAME = 8 * DIV;

    logic       clock;
    logic       reset;
    logic [6:0] displays [7:0];
    logic [1:0] status;
    logic [7:0] an;
    logic [6:0] seg;
    logic       frame_tick;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: position within the frame as a plain cycle number.
    int         m_t;
    logic [6:0] m_shadow [8];
    int         m_fc;
    bit         m_blink;
    logic [7:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_tick;

    calc_display_scan #(
        .DIV(DIV), .DEAD(DEAD), .BLINK_FRAMES(BF), .ERR_STATUS(ERR)
    ) dut (
        .clock(clock),
        .reset(reset),
        .displays(displays),
        .status(status),
        .an(an),
        .seg(seg),
        .frame_tick(frame_tick)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Advance the model with the inputs present before the edge, then let the edge happen.
    task automatic tick();
        int  slot;
        int  pos;
        bit  fe;
        if (reset) begin
            m_t      = 0;
            m_fc     = 0;
            m_blink  = 0;
            for (int i = 0; i < 8; i++) m_shadow[i] = 7'h7F;
            exp_an   = 8'hFF;
            exp_seg  = 7'h7F;
            exp_tick = 1'b0;
        end else begin
            slot = m_t / DIV;
            pos  = m_t % DIV;
            fe   = (m_t == FRAME - 1);
            if (pos < DEAD || m_blink) begin
                exp_an  = 8'hFF;
                exp_seg = 7'h7F;
            end else begin
                exp_an  = ~(8'd1 << slot);
                exp_seg = m_shadow[slot];
            end
            exp_tick = fe;
            if (fe) for (int i = 0; i < 8; i++) m_shadow[i] = displays[i];
            if (status != ERR) begin
                m_fc    = 0;
                m_blink = 0;
            end else if (fe) begin
                if (m_fc == BF - 1) begin
                    m_fc    = 0;
                    m_blink = !m_blink;
                end else begin
                    m_fc++;
                end
            end
            m_t = (m_t + 1) % FRAME;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic set_all(input logic [6:0] v);
        for (int i = 0; i < 8; i++) displays[i] = v;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        status = 2'd0;
        set_all(7'h40);
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (an !== 8'hFF || seg !== 7'h7F || frame_tick !== 1'b0) begin
                n_errors++;
                $display("FAIL reset cyc%0d: an=%h seg=%h tick=%b, expected an=ff seg=7f tick=0",
                         c, an, seg, frame_tick);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_first_frame();
        logic [7:0] want_an;
        for (int e = 1; e <= FRAME; e++) begin
            tick();
            want_an = ((e - 1) % DIV == 0) ? 8'hFF : ~(8'd1 << ((e - 1) / DIV));
            n_checks++;
            if (an !== want_an || seg !== 7'h7F || frame_tick !== (e == FRAME)) begin
                n_errors++;
                $display("FAIL first_frame edge%0d: an=%h seg=%h tick=%b, expected an=%h seg=7f tick=%b",
                         e, an, seg, frame_tick, want_an, (e == FRAME));
            end
        end
    endtask

    task automatic test_scan_order();
        logic [7:0] want_an;
        logic [6:0] want_seg;
        for (int e = FRAME + 1; e <= 2 * FRAME; e++) begin
            tick();
            if (e == 40) displays[3] = 7'h79;
            want_an  = ((e - 33) % DIV == 0) ? 8'hFF : ~(8'd1 << ((e - 33) / DIV));
            want_seg = (want_an == 8'hFF) ? 7'h7F : 7'h40;
            n_checks++;
            if (an !== want_an || seg !== want_seg || frame_tick !== (e == 2 * FRAME)) begin
                n_errors++;
                $display("FAIL scan_order edge%0d: an=%h seg=%h tick=%b, expected an=%h seg=%h tick=%b",
                         e, an, seg, frame_tick, want_an, want_seg, (e == 2 * FRAME));
            end
        end
    endtask

    task automatic test_coherence();
        for (int e = 2 * FRAME + 1; e <= 3 * FRAME; e++) begin
            tick();
            n_checks++;
            if (an !== exp_an || seg !== exp_seg || frame_tick !== exp_tick) begin
                n_errors++;
                $display("FAIL coherence edge%0d: an=%h seg=%h tick=%b, expected an=%h seg=%h tick=%b",
                         e, an, seg, frame_tick, exp_an, exp_seg, exp_tick);
            end
            if (e >= 78 && e <= 80) begin
                n_checks++;
                if (an !== 8'hF7 || seg !== 7'h79) begin
                    n_errors++;
                    $display("FAIL coherence_slot3 edge%0d: an=%h seg=%h, expected an=f7 seg=79",
                             e, an, seg);
                end
            end
        end
    endtask

    task automatic test_blink();
        int driving;
        status = ERR;
        for (int f = 0; f < 7; f++) begin
            driving = 0;
            for (int c = 0; c < FRAME; c++) begin
                if (f == 6 && c == 16) status = 2'd0;
                tick();
                if (an !== 8'hFF) driving++;
                n_checks++;
                if (an !== exp_an || seg !== exp_seg || frame_tick !== exp_tick) begin
                    n_errors++;
                    $display("FAIL blink f%0d c%0d: an=%h seg=%h tick=%b, expected an=%h seg=%h tick=%b",
                             f, c, an, seg, frame_tick, exp_an, exp_seg, exp_tick);
                end
                if (f == 6 && c == 17) begin
                    n_checks++;
                    if (an === 8'hFF) begin
                        n_errors++;
                        $display("FAIL blink_resume: an=%h, expected a driving digit", an);
                    end
                end
            end
            if (f < 6) begin
                n_checks++;
                if (driving !== (((f / 2) % 2 == 0) ? 24 : 0)) begin
                    n_errors++;
                    $display("FAIL blink_frame%0d: driving cycles=%0d, expected %0d",
                             f, driving, (((f / 2) % 2 == 0) ? 24 : 0));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] want_an;
        while (m_t != 5 * DIV + 2) tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if (an !== 8'hFF || seg !== 7'h7F || frame_tick !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid: an=%h seg=%h tick=%b, expected an=ff seg=7f tick=0",
                     an, seg, frame_tick);
        end
        reset = 1'b0;
        set_all(7'h40);
        for (int e = 1; e <= FRAME; e++) begin
            tick();
            want_an = ((e - 1) % DIV == 0) ? 8'hFF : ~(8'd1 << ((e - 1) / DIV));
            n_checks++;
            if (an !== want_an || seg !== 7'h7F || frame_tick !== (e == FRAME)) begin
                n_errors++;
                $display("FAIL reset_mid_replay edge%0d: an=%h seg=%h tick=%b, expected an=%h seg=7f tick=%b",
                         e, an, seg, frame_tick, want_an, (e == FRAME));
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1000; c++) begin
            for (int i = 0; i < 8; i++) displays[i] = 7'($urandom);
            if ($urandom_range(63) == 0) status = 2'($urandom);
            else if ($urandom_range(127) == 0) status = ERR;
            reset = ($urandom_range(299) == 0);
            tick();
            reset = 1'b0;
            n_checks++;
            if (an !== exp_an || seg !== exp_seg || frame_tick !== exp_tick) begin
                n_errors++;
                $display("FAIL random c%0d: an=%h seg=%h tick=%b, expected an=%h seg=%h tick=%b",
                         c, an, seg, frame_tick, exp_an, exp_seg, exp_tick);
            end
            n_checks++;
            if (!(an === 8'hFF || $countones(an) == 7) || (an === 8'hFF && seg !== 7'h7F)) begin
                n_errors++;
                $display("FAIL invariant c%0d: an=%h seg=%h, expected ff/7f or one-hot-low an",
                         c, an, seg);
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        status = 2'd0;
        set_all(7'h7F);
        test_reset();
        test_first_frame();
        test_scan_order();
        test_coherence();
        test_blink();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
